ones_fill: RTL and testbench
============================

ONES_FILL -- requirements
Module: ones_fill

Interface
REQ-001 Parameter WIDTH, default 8, output word width in bits (WIDTH >= 2).
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), width of the count input.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to generate a word; sampled only when ready=1.
REQ-006 count_in  input  CNT_W  number of 1 bits to place in the output word.
REQ-007 ready  output  1  high when block accepts start (state IDLE).
REQ-008 done  output  1  one-cycle pulse, data_out newly valid.
REQ-009 data_out  output  WIDTH  thermometer word, count ones right-justified (LSBs set).

Function
REQ-010 The block SHALL be the generator counterpart of the ones-counting control path: given N, it serially builds a word containing exactly N ones.
REQ-011 FSM SHALL have exactly four states: IDLE, CHECK, FILL, DONE.
REQ-012 IDLE: ready=1; on start=1, cnt <= sat(count_in), shreg <= 0, next state CHECK; start=0 stays IDLE.
REQ-013 sat(x) SHALL be min(x, WIDTH); counts above WIDTH saturate, never wrap.
REQ-014 CHECK: if cnt==0 next DONE, else next FILL; no datapath change.
REQ-015 FILL: shreg <= {shreg[WIDTH-2:0],1'b1}, cnt <= cnt-1, next CHECK.
REQ-016 On the CHECK->DONE edge, data_out SHALL load shreg.
REQ-017 DONE: done=1 for exactly one cycle, next IDLE unconditionally.
REQ-018 data_out SHALL hold its value from DONE until the next DONE load or reset.
REQ-019 Latency: start sampled at edge E -> done high in cycle 2N+2 after E (N = sat(count_in)); N=0 -> 2 cycles, N=WIDTH -> 2*WIDTH+2.
REQ-020 ready SHALL be combinational on state only (PS==IDLE); start while ready=0 SHALL be ignored, not queued.
REQ-021 count_in SHALL be sampled only at acceptance; later changes have no effect on the current operation.
REQ-022 start held high continuously SHALL produce back-to-back operations, one accepted per IDLE visit (one idle cycle between done and next CHECK).
REQ-023 done and ready SHALL never be high in the same cycle.
REQ-024 cnt SHALL never decrement below 0; FILL is unreachable with cnt==0.

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, cnt=0, shreg=0, data_out=0, done=0; ready=1 while rst is held.
REQ-026 Reset mid-operation (CHECK or FILL) SHALL abort without a done pulse; data_out SHALL read 0 afterwards.
REQ-027 First start accepted on the first rising edge after rst deasserts.

Verification (WIDTH=8)
REQ-028 Reset, start with count_in=3 -> done in cycle 8 after acceptance, data_out=8'b0000_0111, ready returns next cycle.
REQ-029 count_in=0 -> done 2 cycles after acceptance, data_out=8'h00; count_in=8 -> done after 18 cycles, data_out=8'hFF.
REQ-030 count_in=15 (saturation) -> identical to count_in=8: data_out=8'hFF, latency 18.
REQ-031 start pulsed and count_in changed to 1 while busy with count 5 -> ignored; single done, data_out=8'h1F.
REQ-032 rst asserted during FILL of count 6 -> no done, data_out=8'h00, ready=1 immediately; subsequent count 2 -> data_out=8'h03.
REQ-033 start held high, count_in=1 -> done every 5 cycles, data_out=8'h01, done and ready never coincide.

Source files
------------

// File: rtl/ones_fill.sv
// ones_fill: serially builds a right-justified thermometer word holding N ones.
// Ports: clk, rst (async, active-high), start/count_in request, ready, done pulse, data_out.
module ones_fill #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   count_sat;

    // Requests above WIDTH clamp to a full word instead of wrapping.
    assign count_sat = (count_in > MAX_CNT) ? MAX_CNT : count_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = count_sat;
                    shreg_d = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // Publish the word on the way out so it is valid with done.
                if (cnt_q == '0) begin
                    data_d  = shreg_q;
                    state_d = DONE;
                end else begin
                    state_d = FILL;
                end
            end
            FILL: begin
                // Only entered with cnt_q != 0, so the decrement never wraps.
                shreg_d = {shreg_q[WIDTH-2:0], 1'b1};
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = CHECK;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready    = (state_q == IDLE);
    assign done     = (state_q == DONE);
    assign data_out = data_q;

endmodule

// File: tb/tb_ones_fill.sv
// tb_ones_fill: randomized and directed checks of ones_fill (WIDTH=8)
// against a count-to-word arithmetic model.
module tb_ones_fill;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [CW-1:0] count_in;
    logic          ready;
    logic          done;
    logic [W-1:0]  data_out;

    int tests;
    int fails;

    ones_fill #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .count_in (count_in),
        .ready    (ready),
        .done     (done),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat_n(input int c);
        return (c > W) ? W : c;
    endfunction

    function automatic logic [W-1:0] exp_word(input int c);
        int n;
        n = sat_n(c);
        return W'((1 << n) - 1);
    endfunction

    // One full operation from a negedge with the block idle.
    task automatic do_op(input int c, input string nm);
        int lat;
        int k;
        logic [W-1:0] w;
        lat = 2 * sat_n(c) + 2;
        w   = exp_word(c);
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_before: got %b want 1", nm, ready);
        end
        start    = 1'b1;
        count_in = CW'(c);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k != lat) begin
            fails++;
            $display("FAIL %s latency: got %0d want %0d", nm, k, lat);
        end
        tests++;
        if (data_out !== w) begin
            fails++;
            $display("FAIL %s data: got %h want %h", nm, data_out, w);
        end
        tests++;
        if (ready !== 1'b0) begin
            fails++;
            $display("FAIL %s ready_with_done: got %b want 0", nm, ready);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            fails++;
            $display("FAIL %s after_done: done=%b ready=%b want 0/1",
                     nm, done, ready);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        count_in = '0;
        repeat (3) @(negedge clk);
        tests++;
        if (ready !== 1'b1 || done !== 1'b0 || data_out !== '0) begin
            fails++;
            $display("FAIL reset: ready=%b done=%b data=%h want 1/0/00",
                     ready, done, data_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_op(3, "basic3");
    endtask

    task automatic test_bounds();
        do_op(0, "zero");
        do_op(8, "full");
        do_op(15, "sat15");
        do_op(9, "sat9");
    endtask

    task automatic test_random();
        int c;
        logic [W-1:0] w;
        for (int i = 0; i < 20; i++) begin
            c = int'($urandom_range(0, 15));
            do_op(c, "random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            w = exp_word(c);
            tests++;
            if (data_out !== w) begin
                fails++;
                $display("FAIL hold: got %h want %h (count %0d)",
                         data_out, w, c);
            end
        end
    endtask

    task automatic test_ignore();
        int nd;
        int dk;
        logic [W-1:0] dv;
        nd = 0;
        dk = -1;
        dv = '0;
        start    = 1'b1;
        count_in = CW'(5);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 2) begin
                start    = 1'b1;
                count_in = CW'(1);
            end
            if (k == 3) start = 1'b0;
            if (done === 1'b1) begin
                nd++;
                dk = k;
                dv = data_out;
            end
            @(negedge clk);
        end
        tests++;
        if (nd != 1) begin
            fails++;
            $display("FAIL ignore_count: got %0d dones want 1", nd);
        end
        tests++;
        if (dk != 12) begin
            fails++;
            $display("FAIL ignore_latency: got %0d want 12", dk);
        end
        tests++;
        if (dv !== 8'h1F) begin
            fails++;
            $display("FAIL ignore_data: got %h want 1f", dv);
        end
    endtask

    task automatic test_reset_mid();
        int nd;
        start    = 1'b1;
        count_in = CW'(6);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (ready !== 1'b1 || done !== 1'b0 || data_out !== '0) begin
            fails++;
            $display("FAIL mid_reset: ready=%b done=%b data=%h want 1/0/00",
                     ready, done, data_out);
        end
        @(negedge clk);
        rst = 1'b0;
        nd  = 0;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        tests++;
        if (nd != 0 || data_out !== '0) begin
            fails++;
            $display("FAIL abort: dones=%0d data=%h want 0/00", nd, data_out);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_op(2, "post_reset");
    endtask

    task automatic test_back_to_back();
        int prev;
        int nd;
        prev     = -1;
        nd       = 0;
        start    = 1'b1;
        count_in = CW'(1);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            tests++;
            if (done === 1'b1 && ready === 1'b1) begin
                fails++;
                $display("FAIL b2b_overlap: done and ready both high at %0d", i);
            end
            if (done === 1'b1) begin
                nd++;
                tests++;
                if (data_out !== 8'h01) begin
                    fails++;
                    $display("FAIL b2b_data: got %h want 01", data_out);
                end
                if (prev >= 0) begin
                    tests++;
                    if (i - prev != 5) begin
                        fails++;
                        $display("FAIL b2b_period: got %0d want 5", i - prev);
                    end
                end
                prev = i;
            end
        end
        start = 1'b0;
        tests++;
        if (nd != 8) begin
            fails++;
            $display("FAIL b2b_count: got %0d want 8", nd);
        end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_bounds();
        test_ignore();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
